ioctl_upload_reader: RTL
========================

// Module: ioctl_upload_reader
// PURPOSE
//  Read-side companion to the HPS ioctl download path: services hps_io upload
//  reads (ioctl_rd) by fetching bytes from the 64 KiB system RAM and returning
//  them on ioctl_din, holding ioctl_wait high while a fetch is in flight.
//  Sits between hps_io and a shared RAM read port arbitrated with the CPU.
//  Used for RAM dumps and save-data export; write path stays in the top level.
// PARAMETERS
//  AW      16     RAM address width; valid window is 0 .. 2**AW-1
//  RD_LAT  1      RAM read latency in clk_sys cycles after the grant cycle (1..3)
//  FILL    8'hFF  byte returned for addresses outside the RAM window
// PORTS
//  clk_sys        in   1   system clock; the only clock
//  reset          in   1   synchronous, active-high reset
//  ioctl_upload   in   1   hps_io upload session active
//  ioctl_rd       in   1   one-cycle read strobe from hps_io
//  ioctl_addr     in   25  byte address of the read
//  ioctl_din      out  8   returned byte; holds until the next fetch completes
//  ioctl_wait     out  1   high while a fetch is pending; hps_io stalls
//  mem_req        out  1   RAM read request; held until granted
//  mem_addr       out  AW  RAM read address; stable while mem_req is high
//  mem_gnt        in   1   arbiter grant; request accepted in the cycle both are high
//  mem_q          in   8   RAM data, valid RD_LAT cycles after the grant cycle
//  upload_active  out  1   registered copy of ioctl_upload
//  byte_count     out  25  bytes returned in the current session
//  upload_done    out  1   one-cycle pulse on the falling edge of ioctl_upload
// BEHAVIOUR
//  Reset values: ioctl_din=0, ioctl_wait=0, mem_req=0, mem_addr=0,
//   upload_active=0, byte_count=0, upload_done=0, FSM=IDLE.
//  FSM states: IDLE, REQ, LAT, DONE.
//  IDLE: if ioctl_upload && ioctl_rd:
//   - addr < 2**AW: latch addr, mem_req=1, wait=1, go to REQ.
//   - addr >= 2**AW (any of bits 24:AW set): wait=1, go to DONE with FILL
//     selected; no RAM access.
//  REQ: hold mem_req and mem_addr. On mem_gnt: drop mem_req, load the latency
//   counter with RD_LAT, go to LAT.
//  LAT: decrement the counter. When it reaches 0, capture mem_q into
//   ioctl_din and go to DONE.
//  DONE: wait=0, byte_count+=1, go to IDLE.
//  Latency: with grant in the request cycle, ioctl_wait is high for RD_LAT+2
//   cycles and ioctl_din is valid in the cycle ioctl_wait falls.
//   An out-of-range read holds ioctl_wait for exactly 1 cycle.
//  ioctl_rd arriving while not in IDLE is ignored; hps_io does not issue it
//   while ioctl_wait is high.
//  ioctl_upload falling in any state: abort to IDLE, mem_req=0, wait=0,
//   ioctl_din unchanged, byte_count not incremented for the aborted byte.
//   upload_done pulses one cycle later.
//  ioctl_upload rising: byte_count clears to 0.
//  ioctl_rd while ioctl_upload is low: ignored.
//  byte_count wraps modulo 2**25.
//  Reset asserted mid-operation: immediate return to reset values.
//   A pending mem_req is dropped; a grant already in flight is discarded.
// TESTING
//  T1 RAM[0x1234]=0x5A, gnt tied high, RD_LAT=1, rd addr 0x1234 -> wait high
//     3 cycles, then ioctl_din=0x5A; byte_count=1.
//  T2 gnt withheld 5 cycles, rd addr 0x0010 (RAM=0xC3) -> mem_req and
//     mem_addr=0x0010 held stable 5 cycles; din=0xC3; wait high 8 cycles.
//  T3 rd addr 0x10000 -> no mem_req, din=0xFF after a 1-cycle wait,
//     byte_count increments.
//  T4 sequential reads 0x0000..0x00FF with random grant delays -> every byte
//     matches RAM; byte_count=256; upload_done pulses once after upload falls.
//  T5 drop ioctl_upload while in REQ -> mem_req=0 and wait=0 next cycle,
//     byte_count unchanged, upload_done=1 for 1 cycle.
//  T6 reset asserted in LAT -> all outputs at reset values next cycle; the
//     following read returns correct data.

Source files
------------

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: services hps_io upload reads by fetching bytes from
// system RAM through a shared, arbitrated read port.
module ioctl_upload_reader #(
    parameter int unsigned AW     = 16,
    parameter int unsigned RD_LAT = 1,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic [7:0]    mem_q,
    output logic          upload_active,
    output logic [24:0]   byte_count,
    output logic          upload_done
);

    localparam int unsigned CW = 2;
    localparam logic [24:0] WIN_END = 25'(1) << AW;

    typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] lat_cnt;
    logic          in_range;

    // Address falls inside the RAM window
    assign in_range = (ioctl_addr < WIN_END);

    // Fetch FSM, session tracking and byte counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            ioctl_din     <= '0;
            ioctl_wait    <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            upload_active <= 1'b0;
            byte_count    <= '0;
            upload_done   <= 1'b0;
        end else begin
            upload_active <= ioctl_upload;
            upload_done   <= upload_active & ~ioctl_upload;
            if (!ioctl_upload) begin
                // session ended: abandon any fetch, keep last returned byte
                state      <= IDLE;
                mem_req    <= 1'b0;
                ioctl_wait <= 1'b0;
            end else begin
                if (!upload_active) begin
                    byte_count <= '0;
                end
                case (state)
                    IDLE: begin
                        if (ioctl_rd) begin
                            ioctl_wait <= 1'b1;
                            if (in_range) begin
                                mem_addr <= ioctl_addr[AW-1:0];
                                mem_req  <= 1'b1;
                                state    <= REQ;
                            end else begin
                                ioctl_din <= FILL;
                                state     <= DONE;
                            end
                        end
                    end
                    REQ: begin
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            lat_cnt <= CW'(RD_LAT);
                            state   <= LAT;
                        end
                    end
                    LAT: begin
                        lat_cnt <= lat_cnt - CW'(1);
                        if (lat_cnt == CW'(1)) begin
                            ioctl_din <= mem_q;
                            state     <= DONE;
                        end
                    end
                    DONE: begin
                        ioctl_wait <= 1'b0;
                        byte_count <= byte_count + 25'd1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
